vga_pmod_out: RTL and testbench

VGA_PMOD_OUT -- requirements
Module: vga_pmod_out

---
 rtl/vga_pmod_out.sv | 130 +++++++++++++
 tb/tb_vga_pmod_out.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pmod_out.sv
// vga_pmod_out: registers the text renderer's syncs and monochrome pixel onto
// the TinyVGA PMOD bus. Colour is gated by an hsync cadence lock, and the
// foreground colour steps through an 8-entry palette driven by a frame counter.
module vga_pmod_out #(
    parameter int PAL_SHIFT = 5,
    parameter int WDOG_MAX  = 1023
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       pix_in,
    output logic [7:0] uo_out,
    output logic       locked
);

    typedef enum logic {
        ACQUIRE = 1'b0,
        LOCKED  = 1'b1
    } state_t;

    localparam logic [9:0] WDOG_SAT = 10'(WDOG_MAX);

    state_t     state;
    state_t     state_nx;
    logic       armed;
    logic       armed_nx;
    logic       hs_prev;
    logic       vs_prev;
    logic [9:0] wdog;
    logic [7:0] frame_cnt;

    logic       hs_fall;
    logic       vs_fall;
    logic       wdog_sat;
    logic [2:0] pal_idx;
    logic [5:0] colour;

    // 6-bit RRGGBB palette entry for a 3-bit index
    function automatic logic [5:0] palette(input logic [2:0] idx);
        logic [5:0] c;
        case (idx)
            3'd0:    c = 6'b111111;
            3'd1:    c = 6'b110000;
            3'd2:    c = 6'b111100;
            3'd3:    c = 6'b001100;
            3'd4:    c = 6'b001111;
            3'd5:    c = 6'b000011;
            3'd6:    c = 6'b110011;
            default: c = 6'b101010;
        endcase
        return c;
    endfunction

    // Pack syncs and RRGGBB onto the PMOD pin order:
    // [0]R1 [1]G1 [2]B1 [3]VSYNC [4]R0 [5]G0 [6]B0 [7]HSYNC
    function automatic logic [7:0] pmod_pack(input logic hs, input logic vs,
                                             input logic [5:0] c);
        return {hs, c[0], c[2], c[4], vs, c[1], c[3], c[5]};
    endfunction

    assign hs_fall  = hs_prev & ~hsync_in;
    assign vs_fall  = vs_prev & ~vsync_in;
    assign wdog_sat = (wdog == WDOG_SAT);
    assign pal_idx  = frame_cnt[PAL_SHIFT+2:PAL_SHIFT];
    // Qualification uses the pre-update state, so a lock change shows up on
    // RGB from the next input cycle onward.
    assign colour   = (pix_in && state == LOCKED) ? palette(pal_idx) : 6'b000000;
    assign locked   = (state == LOCKED);

    // Lock acquisition / loss decisions from the current edge and watchdog
    always_comb begin
        state_nx = state;
        armed_nx = armed;
        case (state)
            ACQUIRE: begin
                if (hs_fall) begin
                    if (!armed) begin
                        armed_nx = 1'b1;
                    end else if (!wdog_sat) begin
                        state_nx = LOCKED;
                    end
                    // An edge after a saturated gap stays armed: it becomes
                    // the new first edge of the cadence.
                end
            end
            LOCKED: begin
                if (wdog_sat && !hs_fall) begin
                    state_nx = ACQUIRE;
                    armed_nx = 1'b0;
                end
            end
            default: begin
                state_nx = ACQUIRE;
                armed_nx = 1'b0;
            end
        endcase
    end

    // State, edge history, watchdog, frame counter and registered PMOD output
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ACQUIRE;
            armed     <= 1'b0;
            hs_prev   <= 1'b1;
            vs_prev   <= 1'b1;
            wdog      <= '0;
            frame_cnt <= '0;
            uo_out    <= 8'h88;
        end else begin
            state   <= state_nx;
            armed   <= armed_nx;
            hs_prev <= hsync_in;
            vs_prev <= vsync_in;

            if (hs_fall) begin
                wdog <= '0;
            end else if (!wdog_sat) begin
                wdog <= wdog + 10'd1;
            end

            if (vs_fall && state == LOCKED) begin
                frame_cnt <= frame_cnt + 8'd1;
            end

            uo_out <= pmod_pack(hsync_in, vsync_in, colour);
        end
    end

endmodule

// File: tb/tb_vga_pmod_out.sv
// tb_vga_pmod_out: randomized and directed scenarios for vga_pmod_out,
// compared against an event-level reference model of the lock/palette rules.
module tb_vga_pmod_out;

    localparam int WDOG_MAX = 1023;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       hsync_in = 1'b1;
    logic       vsync_in = 1'b1;
    logic       pix_in = 1'b0;
    logic [7:0] uo_out;
    logic       locked;

    int checks = 0;
    int errors = 0;

    vga_pmod_out #(.PAL_SHIFT(5), .WDOG_MAX(WDOG_MAX)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .hsync_in (hsync_in),
        .vsync_in (vsync_in),
        .pix_in   (pix_in),
        .uo_out   (uo_out),
        .locked   (locked)
    );

    always #5 clk = ~clk;

    // Reference model: lock tracked as "have we seen a first edge" plus the
    // unbounded number of cycles since the last hsync fall.
    bit         m_prev_h = 1'b1;
    bit         m_prev_v = 1'b1;
    bit         m_have_first = 1'b0;
    bit         m_lock = 1'b0;
    int         m_since = 0;
    int         m_frames = 0;
    logic [7:0] exp_uo = 8'h88;
    logic       exp_locked = 1'b0;
    logic [5:0] pal [8] = '{6'b111111, 6'b110000, 6'b111100, 6'b001100,
                            6'b001111, 6'b000011, 6'b110011, 6'b101010};
    int         keep_cnt = 0;

    task automatic model_step(input bit r, input bit h, input bit v, input bit p);
        bit hf, vf, timed_out;
        logic [5:0] col;
        if (!r) begin
            m_prev_h = 1'b1; m_prev_v = 1'b1;
            m_have_first = 1'b0; m_lock = 1'b0;
            m_since = 0; m_frames = 0;
            exp_uo = 8'h88; exp_locked = 1'b0;
            return;
        end
        hf = m_prev_h && !h;
        vf = m_prev_v && !v;
        timed_out = (m_since >= WDOG_MAX);
        col = (p && m_lock) ? pal[(m_frames / 32) % 8] : 6'b000000;
        exp_uo[7] = h;      exp_uo[3] = v;
        exp_uo[0] = col[5]; exp_uo[4] = col[4];
        exp_uo[1] = col[3]; exp_uo[5] = col[2];
        exp_uo[2] = col[1]; exp_uo[6] = col[0];
        if (m_lock && vf) m_frames = (m_frames + 1) % 256;
        if (!m_lock) begin
            if (hf) begin
                if (!m_have_first) m_have_first = 1'b1;
                else if (!timed_out) m_lock = 1'b1;
            end
        end else if (timed_out && !hf) begin
            m_lock = 1'b0;
            m_have_first = 1'b0;
        end
        m_since = hf ? 0 : m_since + 1;
        m_prev_h = h;
        m_prev_v = v;
        exp_locked = m_lock;
    endtask

    task automatic tick(input bit r, input bit h, input bit v, input bit p);
        rst_n = r; hsync_in = h; vsync_in = v; pix_in = p;
        @(posedge clk);
        model_step(r, h, v, p);
        #1;
    endtask

    // n-1 cycles with hsync high, then one cycle low (falling edge)
    task automatic hgap(input int n);
        for (int i = 0; i < n - 1; i++) tick(1'b1, 1'b1, 1'b1, 1'($urandom));
        tick(1'b1, 1'b0, 1'b1, 1'($urandom));
    endtask

    // Cycle with hsync kept alive by a 300-cycle cadence
    task automatic ktick(input bit v, input bit p, input bit h_high);
        bit h;
        h = (keep_cnt % 300 == 0 && !h_high) ? 1'b0 : 1'b1;
        keep_cnt++;
        tick(1'b1, h, v, p);
    endtask

    task automatic vpulses(input int n);
        for (int i = 0; i < n; i++) begin
            ktick(1'b0, 1'($urandom), 1'b0);
            ktick(1'b1, 1'($urandom), 1'b0);
        end
    endtask

    task automatic test_reset;
        tick(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
        tick(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
        checks++;
        if (uo_out !== 8'h88) begin errors++; $display("FAIL reset_uo: got %h expected 88", uo_out); end
        checks++;
        if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b expected 0", locked); end
    endtask

    task automatic test_lock;
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b1, 1'b1);
        tick(1'b1, 1'b0, 1'b1, 1'b1);
        checks++;
        if (locked !== 1'b0) begin errors++; $display("FAIL lock_first_edge: got %b expected 0", locked); end
        for (int i = 0; i < 799; i++) tick(1'b1, 1'b1, 1'b1, 1'b1);
        checks++;
        if (locked !== 1'b0) begin errors++; $display("FAIL lock_before_second: got %b expected 0", locked); end
        tick(1'b1, 1'b0, 1'b1, 1'b1);
        checks++;
        if (locked !== 1'b1) begin errors++; $display("FAIL lock_second_edge: got %b expected 1", locked); end
        checks++;
        if (uo_out !== 8'h08) begin errors++; $display("FAIL lock_edge_rgb: got %h expected 08", uo_out); end
        tick(1'b1, 1'b1, 1'b1, 1'b1);
        checks++;
        if (uo_out !== 8'hFF) begin errors++; $display("FAIL lock_white: got %h expected ff", uo_out); end
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        checks++;
        if (uo_out !== 8'h88) begin errors++; $display("FAIL lock_bg: got %h expected 88", uo_out); end
    endtask

    // Continues from test_lock: last edge was 2 cycles ago
    task automatic test_timeout;
        for (int i = 0; i < 1200; i++) begin
            tick(1'b1, 1'b1, 1'b1, 1'($urandom));
            checks++;
            if (uo_out !== exp_uo || locked !== exp_locked) begin
                errors++;
                $display("FAIL timeout_cycle%0d: got uo=%h locked=%b expected uo=%h locked=%b",
                         i, uo_out, locked, exp_uo, exp_locked);
            end
            if (i + 3 == 1023) begin
                checks++;
                if (locked !== 1'b1) begin errors++; $display("FAIL timeout_early: got %b expected 1", locked); end
            end
            if (i + 3 == 1024) begin
                checks++;
                if (locked !== 1'b0) begin errors++; $display("FAIL timeout_drop: got %b expected 0", locked); end
            end
        end
        tick(1'b1, 1'b0, 1'b1, 1'b1);
        checks++;
        if (uo_out !== 8'h08) begin errors++; $display("FAIL timeout_hs_low: got %h expected 08", uo_out); end
        tick(1'b1, 1'b1, 1'b1, 1'b1);
        checks++;
        if (uo_out !== 8'h88) begin errors++; $display("FAIL timeout_hs_high: got %h expected 88", uo_out); end
    endtask

    task automatic test_palette;
        tick(1'b0, 1'b1, 1'b1, 1'b1);
        tick(1'b1, 1'b0, 1'b1, 1'b1);
        hgap(800);
        checks++;
        if (locked !== 1'b1) begin errors++; $display("FAIL pal_lock: got %b expected 1", locked); end
        keep_cnt = 1;
        vpulses(32);
        ktick(1'b1, 1'b1, 1'b1);
        checks++;
        if (uo_out !== 8'h99) begin errors++; $display("FAIL pal_red: got %h expected 99", uo_out); end
        vpulses(224);
        ktick(1'b1, 1'b1, 1'b1);
        checks++;
        if (uo_out !== 8'hFF) begin errors++; $display("FAIL pal_wrap: got %h expected ff", uo_out); end
        vpulses(200);
        ktick(1'b1, 1'b1, 1'b1);
        checks++;
        if (uo_out !== 8'hDD) begin errors++; $display("FAIL pal_idx6: got %h expected dd", uo_out); end
        checks++;
        if (uo_out !== exp_uo || locked !== 1'b1) begin
            errors++;
            $display("FAIL pal_model: got uo=%h locked=%b expected uo=%h locked=1", uo_out, locked, exp_uo);
        end
        // Reset in the middle of a locked frame, with edges on both syncs
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (uo_out !== 8'h88 || locked !== 1'b0) begin
            errors++;
            $display("FAIL midreset: got uo=%h locked=%b expected uo=88 locked=0", uo_out, locked);
        end
        tick(1'b1, 1'b1, 1'b1, 1'b1);
        tick(1'b1, 1'b0, 1'b1, 1'b1);
        checks++;
        if (locked !== 1'b0) begin errors++; $display("FAIL relock_one_edge: got %b expected 0", locked); end
        hgap(800);
        checks++;
        if (locked !== 1'b1) begin errors++; $display("FAIL relock: got %b expected 1", locked); end
        tick(1'b1, 1'b1, 1'b1, 1'b1);
        checks++;
        if (uo_out !== 8'hFF) begin errors++; $display("FAIL relock_frame0: got %h expected ff", uo_out); end
    endtask

    task automatic test_boundary;
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        hgap(1024);
        checks++;
        if (locked !== 1'b0) begin errors++; $display("FAIL bound_sat_edge: got %b expected 0", locked); end
        hgap(800);
        checks++;
        if (locked !== 1'b1) begin errors++; $display("FAIL bound_third_edge: got %b expected 1", locked); end
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        hgap(1023);
        checks++;
        if (locked !== 1'b1) begin errors++; $display("FAIL bound_below_sat: got %b expected 1", locked); end
    endtask

    task automatic test_random;
        for (int i = 0; i < 4000; i++) begin
            tick(1'($urandom_range(0, 1499) != 0), 1'($urandom_range(0, 349) != 0),
                 1'($urandom_range(0, 199) != 0), 1'($urandom));
            checks++;
            if (uo_out !== exp_uo || locked !== exp_locked) begin
                errors++;
                $display("FAIL random_cycle%0d: got uo=%h locked=%b expected uo=%h locked=%b",
                         i, uo_out, locked, exp_uo, exp_locked);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_timeout();
        test_palette();
        test_boundary();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
